// File: rtl/tag_array_pkg.sv
// tag_array_pkg: shared types and helpers for the set-associative tag store.
//   state_e           - controller states of tag_array_assoc
//   age_t             - per-way recency age (0 = MRU, WAYS-1 = LRU), wide enough for 8 ways
//   age_next()        - age of one way after another way is touched or demoted
//   TAG_ARRAY_ENTRY() - packed {valid, dirty, tag} entry for a given tag width

`ifndef TAG_ARRAY_ENTRY
`define TAG_ARRAY_ENTRY(TW) struct packed { logic valid; logic dirty; logic [(TW)-1:0] tag; }
`endif

package tag_array_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESP  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam int AGE_W = 3;
    typedef logic [AGE_W-1:0] age_t;

    // New age of a way whose current age is 'age' when the way currently at
    // 'ref_age' is touched (moved to MRU) or demoted (moved to LRU).
    function automatic age_t age_next(age_t age, age_t ref_age, logic demote, age_t max_age);
        age_t r;
        r = age;
        if (demote) begin
            if (age == ref_age)
                r = max_age;
            else if (age > ref_age)
                r = age - age_t'(1);
        end else begin
            if (age == ref_age)
                r = '0;
            else if (age < ref_age)
                r = age + age_t'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/tag_lru_set.sv
// tag_lru_set: true-LRU age vector for one set.
//   clk, rst_n                 - clock, synchronous active-low reset
//   clr                        - restore ages to way-index order (flush)
//   touch_en/touch_way         - lookup hit: make way MRU (applied first)
//   upd_en/upd_demote/upd_way  - write: make way MRU, or LRU when demoting (applied last)
//   victim                     - way currently holding the LRU age

module tag_lru_set
    import tag_array_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int WAY_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             touch_en,
    input  logic [WAY_W-1:0] touch_way,
    input  logic             upd_en,
    input  logic             upd_demote,
    input  logic [WAY_W-1:0] upd_way,
    output logic [WAY_W-1:0] victim
);

    localparam age_t MAX_AGE = age_t'(WAYS - 1);

    age_t ages_q   [WAYS];
    age_t ages_mid [WAYS];
    age_t ages_d   [WAYS];
    age_t ref0;
    age_t ref1;

    // Two updates can land on the same edge: the lookup touch is applied to
    // the current ages, then the write update is applied on top so the write
    // decides the final order.
    always_comb begin
        ref0 = '0;
        for (int w = 0; w < WAYS; w++)
            if (WAY_W'(w) == touch_way)
                ref0 = ages_q[w];
        for (int w = 0; w < WAYS; w++)
            ages_mid[w] = touch_en ? age_next(ages_q[w], ref0, 1'b0, MAX_AGE) : ages_q[w];
        ref1 = '0;
        for (int w = 0; w < WAYS; w++)
            if (WAY_W'(w) == upd_way)
                ref1 = ages_mid[w];
        for (int w = 0; w < WAYS; w++)
            ages_d[w] = upd_en ? age_next(ages_mid[w], ref1, upd_demote, MAX_AGE) : ages_mid[w];
    end

    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (!rst_n || clr)
                ages_q[w] <= age_t'(w);
            else
                ages_q[w] <= ages_d[w];
        end
    end

    always_comb begin
        victim = '0;
        for (int w = 0; w < WAYS; w++)
            if (ages_q[w] == MAX_AGE)
                victim = WAY_W'(w);
    end

endmodule

// File: rtl/tag_array_assoc.sv
// tag_array_assoc: set-associative tag store with registered lookup,
// true-LRU replacement and a one-set-per-cycle flush walk.
//   TA_clk, rst_n                 - clock, synchronous active-low reset
//   lk_req/lk_index/lk_tag        - lookup request (accepted while lk_ready)
//   lk_ready, lk_done             - accept strobe, one-cycle result pulse
//   lk_hit/lk_way/lk_dirty        - hit flag, hit or victim way, its dirty bit
//   vic_valid/vic_tag             - victim holds a valid line / its tag
//   wr_en/wr_index/wr_way/wr_tag/wr_valid/wr_dirty - single entry write
//   flush, flush_busy             - start invalidate-all walk / walk in progress

module tag_array_assoc
    import tag_array_pkg::*;
#(
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int TAG_W = 5,
    parameter int IDX_W = $clog2(SETS),
    parameter int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic             TA_clk,
    input  logic             rst_n,
    input  logic             lk_req,
    input  logic [IDX_W-1:0] lk_index,
    input  logic [TAG_W-1:0] lk_tag,
    output logic             lk_ready,
    output logic             lk_done,
    output logic             lk_hit,
    output logic [WAY_W-1:0] lk_way,
    output logic             lk_dirty,
    output logic             vic_valid,
    output logic [TAG_W-1:0] vic_tag,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [WAY_W-1:0] wr_way,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             wr_valid,
    input  logic             wr_dirty,
    input  logic             flush,
    output logic             flush_busy
);

    typedef `TAG_ARRAY_ENTRY(TAG_W) entry_t;

    entry_t           mem_q [SETS][WAYS];
    state_e           state_q, state_d;
    logic [IDX_W-1:0] fcnt_q, fcnt_d;

    logic             hit_q, dirty_q, vv_q;
    logic [WAY_W-1:0] way_q;
    logic [TAG_W-1:0] vtag_q;

    logic             hit, inv_found;
    logic [WAY_W-1:0] hit_way, inv_way, res_way;
    entry_t           res_entry;
    logic [WAY_W-1:0] lru_vic [SETS];

    logic accept;
    logic wr_ok;

    assign accept = (state_q == IDLE) && lk_req;
    assign wr_ok  = wr_en && (state_q != FLUSH);

    // Compare against the set as it stands before this edge; scanning from
    // the top way down leaves the lowest-numbered match / invalid way.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (mem_q[lk_index][w].valid && (mem_q[lk_index][w].tag == lk_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!mem_q[lk_index][w].valid) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        res_way   = hit ? hit_way : (inv_found ? inv_way : lru_vic[lk_index]);
        res_entry = '0;
        for (int w = 0; w < WAYS; w++)
            if (WAY_W'(w) == res_way)
                res_entry = mem_q[lk_index][w];
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: begin
                if (lk_req) begin
                    state_d = RESP;
                end else if (flush) begin
                    state_d = FLUSH;
                    fcnt_d  = '0;
                end
            end
            RESP:  state_d = IDLE;
            FLUSH: begin
                if (fcnt_q == IDX_W'(SETS - 1))
                    state_d = IDLE;
                else
                    fcnt_d = fcnt_q + IDX_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge TA_clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
            hit_q   <= 1'b0;
            way_q   <= '0;
            dirty_q <= 1'b0;
            vv_q    <= 1'b0;
            vtag_q  <= '0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    mem_q[s][w] <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            if (accept) begin
                hit_q   <= hit;
                way_q   <= res_way;
                dirty_q <= res_entry.dirty;
                vv_q    <= !hit && res_entry.valid;
                vtag_q  <= res_entry.tag;
            end
            if (state_q == FLUSH) begin
                // Tags are left in place; only valid/dirty are cleared.
                for (int w = 0; w < WAYS; w++) begin
                    mem_q[fcnt_q][w].valid <= 1'b0;
                    mem_q[fcnt_q][w].dirty <= 1'b0;
                end
            end else begin
                for (int w = 0; w < WAYS; w++)
                    if (wr_ok && (WAY_W'(w) == wr_way))
                        mem_q[wr_index][w] <= {wr_valid, wr_dirty, wr_tag};
            end
        end
    end

    generate
        for (genvar gi = 0; gi < SETS; gi++) begin : g_lru
            tag_lru_set #(
                .WAYS  (WAYS),
                .WAY_W (WAY_W)
            ) u_lru (
                .clk        (TA_clk),
                .rst_n      (rst_n),
                .clr        ((state_q == FLUSH) && (fcnt_q == IDX_W'(gi))),
                .touch_en   (accept && hit && (lk_index == IDX_W'(gi))),
                .touch_way  (hit_way),
                .upd_en     (wr_ok && wr_valid == 1'b1 && (wr_index == IDX_W'(gi)) || wr_ok && !wr_valid && (wr_index == IDX_W'(gi))),
                .upd_demote (!wr_valid),
                .upd_way    (wr_way),
                .victim     (lru_vic[gi])
            );
        end
    endgenerate

    assign lk_ready   = (state_q == IDLE);
    assign lk_done    = (state_q == RESP);
    assign flush_busy = (state_q == FLUSH);
    assign lk_hit     = hit_q;
    assign lk_way     = way_q;
    assign lk_dirty   = dirty_q;
    assign vic_valid  = vv_q;
    assign vic_tag    = vtag_q;

endmodule

// File: tb/tb_tag_array_assoc.sv
// tb_tag_array_assoc: drives a 2-way and a 4-way instance with identical
// stimulus and checks both against a recency-list reference model.

module tb_tag_array_assoc;

    logic       TA_clk = 1'b0;
    logic       rst_n, lk_req, wr_en, wr_valid, wr_dirty, flush;
    logic [2:0] lk_index, wr_index;
    logic [4:0] lk_tag, wr_tag;
    logic [1:0] wr_way;

    logic       lk_ready_a, lk_done_a, lk_hit_a, lk_dirty_a, vic_valid_a, flush_busy_a;
    logic [0:0] lk_way_a;
    logic [4:0] vic_tag_a;
    logic       lk_ready_b, lk_done_b, lk_hit_b, lk_dirty_b, vic_valid_b, flush_busy_b;
    logic [1:0] lk_way_b;
    logic [4:0] vic_tag_b;

    always #5 TA_clk = ~TA_clk;

    tag_array_assoc #(.SETS(8), .WAYS(2), .TAG_W(5)) dut_a (
        .TA_clk(TA_clk), .rst_n(rst_n), .lk_req(lk_req), .lk_index(lk_index), .lk_tag(lk_tag),
        .lk_ready(lk_ready_a), .lk_done(lk_done_a), .lk_hit(lk_hit_a), .lk_way(lk_way_a),
        .lk_dirty(lk_dirty_a), .vic_valid(vic_valid_a), .vic_tag(vic_tag_a),
        .wr_en(wr_en), .wr_index(wr_index), .wr_way(wr_way[0:0]), .wr_tag(wr_tag),
        .wr_valid(wr_valid), .wr_dirty(wr_dirty), .flush(flush), .flush_busy(flush_busy_a));

    tag_array_assoc #(.SETS(8), .WAYS(4), .TAG_W(5)) dut_b (
        .TA_clk(TA_clk), .rst_n(rst_n), .lk_req(lk_req), .lk_index(lk_index), .lk_tag(lk_tag),
        .lk_ready(lk_ready_b), .lk_done(lk_done_b), .lk_hit(lk_hit_b), .lk_way(lk_way_b),
        .lk_dirty(lk_dirty_b), .vic_valid(vic_valid_b), .vic_tag(vic_tag_b),
        .wr_en(wr_en), .wr_index(wr_index), .wr_way(wr_way), .wr_tag(wr_tag),
        .wr_valid(wr_valid), .wr_dirty(wr_dirty), .flush(flush), .flush_busy(flush_busy_b));

    typedef struct packed {
        logic       hit;
        logic [1:0] way;
        logic       dirty;
        logic       vv;
        logic [4:0] vtag;
    } res_t;

    res_t qa[$];
    res_t qb[$];

    int checks = 0;
    int errors = 0;
    int ts = 0;   // 0 idle, 1 resp, 2 flush
    int fc = 0;

    logic       mv [2][8][4];
    logic       md [2][8][4];
    logic [4:0] mt [2][8][4];
    int         mo [2][8][4];   // recency list, position 0 = most recent

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nw(int d);
        return (d == 0) ? 2 : 4;
    endfunction

    function automatic void m_reset();
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < 8; s++)
                for (int w = 0; w < 4; w++) begin
                    mv[d][s][w] = 1'b0; md[d][s][w] = 1'b0; mt[d][s][w] = '0; mo[d][s][w] = w;
                end
    endfunction

    function automatic void m_move(int d, int s, int w, bit to_back);
        int lst[$];
        for (int p = 0; p < nw(d); p++)
            if (mo[d][s][p] != w) lst.push_back(mo[d][s][p]);
        if (to_back) lst.push_back(w); else lst.push_front(w);
        for (int p = 0; p < nw(d); p++) mo[d][s][p] = lst[p];
    endfunction

    function automatic res_t m_lookup(int d, int s, logic [4:0] t);
        res_t r;
        int   v = -1;
        r = '0;
        for (int w = nw(d) - 1; w >= 0; w--)
            if (mv[d][s][w] && mt[d][s][w] == t) v = w;
        if (v >= 0) begin
            r.hit = 1'b1;
        end else begin
            for (int w = nw(d) - 1; w >= 0; w--)
                if (!mv[d][s][w]) v = w;
            if (v < 0) v = mo[d][s][nw(d) - 1];
        end
        r.way   = 2'(v);
        r.dirty = md[d][s][v];
        r.vv    = !r.hit && mv[d][s][v];
        r.vtag  = mt[d][s][v];
        if (r.hit) m_move(d, s, v, 1'b0);
        return r;
    endfunction

    function automatic void m_write();
        for (int d = 0; d < 2; d++) begin
            int w = int'(wr_way) % nw(d);
            mv[d][wr_index][w] = wr_valid;
            md[d][wr_index][w] = wr_dirty;
            mt[d][wr_index][w] = wr_tag;
            m_move(d, int'(wr_index), w, !wr_valid);
        end
    endfunction

    function automatic void m_flush_set(int s);
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 4; w++) begin
                mv[d][s][w] = 1'b0; md[d][s][w] = 1'b0; mo[d][s][w] = w;
            end
    endfunction

    task automatic cmp_res(string p, res_t e, logic h, logic [1:0] wy, logic dt, logic vv, logic [4:0] vt);
        chk({p, "_hit"}, h, e.hit);
        chk({p, "_way"}, wy, e.way);
        chk({p, "_dirty"}, dt, e.dirty);
        chk({p, "_vic_valid"}, vv, e.vv);
        chk({p, "_vic_tag"}, vt, e.vtag);
    endtask

    // One clock: update the model from the inputs currently driven, step the
    // clock, then check control outputs and any completed lookup.
    task automatic cycle();
        res_t ra, rb;
        if (!rst_n) begin
            m_reset(); ts = 0; qa.delete(); qb.delete();
        end else begin
            case (ts)
                0: begin
                    if (lk_req) begin
                        ra = m_lookup(0, int'(lk_index), lk_tag);
                        rb = m_lookup(1, int'(lk_index), lk_tag);
                        qa.push_back(ra); qb.push_back(rb);
                        if (wr_en) m_write();
                        ts = 1;
                    end else begin
                        if (wr_en) m_write();
                        if (flush) begin ts = 2; fc = 0; end
                    end
                end
                1: begin
                    if (wr_en) m_write();
                    ts = 0;
                end
                default: begin
                    m_flush_set(fc);
                    if (fc == 7) ts = 0; else fc++;
                end
            endcase
        end
        @(posedge TA_clk);
        #1;
        chk("ready_a", lk_ready_a, ts == 0);
        chk("ready_b", lk_ready_b, ts == 0);
        chk("done_a", lk_done_a, ts == 1);
        chk("done_b", lk_done_b, ts == 1);
        chk("busy_a", flush_busy_a, ts == 2);
        chk("busy_b", flush_busy_b, ts == 2);
        if (ts == 1 && qa.size() > 0 && qb.size() > 0) begin
            ra = qa.pop_front();
            rb = qb.pop_front();
            cmp_res("lk_a", ra, lk_hit_a, {1'b0, lk_way_a}, lk_dirty_a, vic_valid_a, vic_tag_a);
            cmp_res("lk_b", rb, lk_hit_b, lk_way_b, lk_dirty_b, vic_valid_b, vic_tag_b);
        end
    endtask

    task automatic lookup(logic [2:0] idx, logic [4:0] t);
        lk_req = 1'b1; lk_index = idx; lk_tag = t;
        cycle();
        lk_req = 1'b0;
        cycle();
        $display("lookup set %0d tag %0h: a hit=%0b way=%0d | b hit=%0b way=%0d",
                 idx, t, lk_hit_a, lk_way_a, lk_hit_b, lk_way_b);
    endtask

    task automatic write(logic [2:0] idx, logic [1:0] wy, logic [4:0] t, logic v, logic d);
        wr_en = 1'b1; wr_index = idx; wr_way = wy; wr_tag = t; wr_valid = v; wr_dirty = d;
        cycle();
        wr_en = 1'b0;
        $display("write set %0d way %0d tag %0h valid %0b dirty %0b", idx, wy, t, v, d);
    endtask

    int  busy_cnt;
    logic prev_done;

    initial begin
        rst_n = 1'b0; lk_req = 1'b0; lk_index = '0; lk_tag = '0; wr_en = 1'b0;
        wr_index = '0; wr_way = '0; wr_tag = '0; wr_valid = 1'b0; wr_dirty = 1'b0; flush = 1'b0;
        cycle(); cycle();
        rst_n = 1'b1;
        chk("rst_hit", lk_hit_a, 1'b0);
        chk("rst_vic_tag", vic_tag_b, 5'h00);

        // Empty set: miss, way 0, no victim line.
        lookup(3'd3, 5'h0A);
        chk("empty_hit", lk_hit_a, 1'b0);
        chk("empty_way", lk_way_a, 1'b0);
        chk("empty_vv", vic_valid_a, 1'b0);

        // Hit on way 1, then a miss evicts way 0 (LRU in the 2-way instance).
        write(3'd3, 2'd0, 5'h11, 1'b1, 1'b1);
        write(3'd3, 2'd1, 5'h0A, 1'b1, 1'b0);
        lookup(3'd3, 5'h0A);
        chk("hit1_hit", lk_hit_a, 1'b1);
        chk("hit1_way", lk_way_a, 1'b1);
        lookup(3'd3, 5'h15);
        chk("lru2_way", lk_way_a, 1'b0);
        chk("lru2_tag", vic_tag_a, 5'h11);
        chk("lru2_dirty", lk_dirty_a, 1'b1);
        chk("b_invalid_victim", lk_way_b, 2'd2);

        // 4-way: fill set 0, touch ways 2 then 0 -> way 1 is LRU.
        for (int k = 0; k < 4; k++) write(3'd0, 2'(k), 5'(k + 1), 1'b1, k[0]);
        lookup(3'd0, 5'h03);
        chk("w4_hit2", lk_way_b, 2'd2);
        lookup(3'd0, 5'h01);
        chk("w4_hit0", lk_way_b, 2'd0);
        lookup(3'd0, 5'h1F);
        chk("w4_vic_way", lk_way_b, 2'd1);
        chk("w4_vic_tag", vic_tag_b, 5'h02);
        chk("w4_vic_dirty", lk_dirty_b, 1'b1);
        chk("w4_vic_valid", vic_valid_b, 1'b1);

        // Same-edge write and lookup: lookup sees pre-write contents.
        lk_req = 1'b1; lk_index = 3'd5; lk_tag = 5'h07;
        wr_en = 1'b1; wr_index = 3'd5; wr_way = 2'd0; wr_tag = 5'h07; wr_valid = 1'b1; wr_dirty = 1'b0;
        cycle();
        lk_req = 1'b0; wr_en = 1'b0;
        cycle();
        chk("same_edge_miss", lk_hit_a, 1'b0);
        lookup(3'd5, 5'h07);
        chk("same_edge_rehit", lk_hit_b, 1'b1);

        // Random mix of lookups and writes, including requests during RESP.
        for (int i = 0; i < 200; i++) begin
            lk_req   = ($urandom_range(0, 1) == 1);
            lk_index = 3'($urandom_range(0, 3));
            lk_tag   = 5'($urandom_range(0, 3));
            wr_en    = ($urandom_range(0, 2) == 0);
            wr_index = 3'($urandom_range(0, 3));
            wr_way   = 2'($urandom_range(0, 3));
            wr_tag   = 5'($urandom_range(0, 3));
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_dirty = ($urandom_range(0, 1) == 1);
            cycle();
        end
        lk_req = 1'b0; wr_en = 1'b0;
        cycle(); cycle();

        // Flush walk: busy for exactly 8 cycles, then everything misses.
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (flush_busy_a) busy_cnt++;
            cycle();
        end
        chk("flush_len", busy_cnt, 8);
        for (int s = 0; s < 8; s++) begin
            lookup(3'(s), 5'($urandom_range(0, 3)));
            chk("post_flush_miss", lk_hit_b, 1'b0);
        end

        // Reset in the middle of a flush walk.
        write(3'd2, 2'd1, 5'h09, 1'b1, 1'b1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        cycle(); cycle(); cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("midflush_rst_busy", flush_busy_a, 1'b0);
        chk("midflush_rst_ready", lk_ready_b, 1'b1);
        write(3'd6, 2'd1, 5'h09, 1'b1, 1'b1);
        lookup(3'd2, 5'h09);
        chk("after_rst_miss", lk_hit_a, 1'b0);
        chk("after_rst_vtag", vic_tag_a, 5'h00);

        // Held request: lk_done never on two consecutive cycles.
        prev_done = 1'b0;
        lk_req = 1'b1; lk_index = 3'd6; lk_tag = 5'h09;
        for (int k = 0; k < 12; k++) begin
            cycle();
            chk("b2b_not_consecutive", prev_done && lk_done_a, 1'b0);
            prev_done = lk_done_a;
        end
        lk_req = 1'b0;
        cycle(); cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
